// File: rtl/mitch_trunc_div_w6_pkg.sv
// Shared constants, FSM encoding and leading-one helper for the Mitchell divider.
package mitch_trunc_div_w6_pkg;
  localparam int W     = 6;
  localparam int FRAC  = W - 1;
  localparam int Q_OFS = 11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOG  = 3'd1,
    SUB  = 3'd2,
    ALOG = 3'd3,
    OUT  = 3'd4
  } state_t;

  // Index of the highest set bit; 0 for an all-zero word.
  function automatic logic [3:0] lod16(input logic [15:0] v);
    lod16 = 4'd0;
    for (int i = 0; i < 16; i++)
      if (v[i]) lod16 = 4'(i);
  endfunction
endpackage

// File: rtl/mitch_div_antilog.sv
// Antilog: {1,f} scaled by 2^(k+Q_OFS) into Q16.16, shifted-out bits dropped.
module mitch_div_antilog #(
  parameter int FRAC = 5
) (
  input  logic [5:0]      k,
  input  logic [FRAC-1:0] f,
  output logic [31:0]     mag
);
  import mitch_trunc_div_w6_pkg::*;

  logic [31:0] m;
  logic [6:0]  e;

  always_comb begin
    m   = {{(31-FRAC){1'b0}}, 1'b1, f};
    e   = {k[5], k} + 7'(Q_OFS);
    mag = e[6] ? (m >> (7'd0 - e)) : (m << e);
  end
endmodule

// File: rtl/mitch_trunc_div_w6.sv
// Mitchell log-domain approximate divider, 16b signed operands, Q16.16 result,
// one operand pair per 5+ cycles through IDLE/LOG/SUB/ALOG/OUT.
module mitch_trunc_div_w6 #(
  parameter int W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic        dz
);
  import mitch_trunc_div_w6_pkg::*;

  localparam int FB = W - 1;

  // Truncated fraction: the FB bits right below the leading one, zero-filled.
  function automatic logic [FB-1:0] frac_of(input logic [15:0] v, input logic [3:0] k);
    frac_of = FB'((v << (4'd15 - k)) >> (15 - FB));
  endfunction

  state_t          state;
  logic [15:0]     x_r, y_r;
  logic [3:0]      kx_r, ky_r;
  logic [FB-1:0]   fx_r, fy_r;
  logic            s1, zx1, zy1;
  logic [5:0]      k_r;
  logic [FB-1:0]   f_r;
  logic            s2, zx2, zy2;
  logic [31:0]     res_r;
  logic            dz_r;

  logic [15:0]     xa, ya;
  logic [3:0]      kx_n, ky_n;
  logic            borrow;
  logic [5:0]      k_n;
  logic [FB-1:0]   f_n;
  logic [31:0]     mag, res_n;

  // One's-complement magnitudes: -1 maps to 0, which decodes the same as 1.
  always_comb begin
    xa     = x_r ^ {16{x_r[15]}};
    ya     = y_r ^ {16{y_r[15]}};
    kx_n   = lod16(xa);
    ky_n   = lod16(ya);
    borrow = fx_r < fy_r;
    k_n    = {2'b00, kx_r} - {2'b00, ky_r} - {5'd0, borrow};
    f_n    = fx_r - fy_r;
    res_n  = zy2 ? 32'hFFFF_FFFF : (zx2 ? 32'd0 : (mag ^ {32{s2}}));
  end

  mitch_div_antilog #(.FRAC(FB)) u_alog (
    .k   (k_r),
    .f   (f_r),
    .mag (mag)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x_r       <= '0;
      y_r       <= '0;
      kx_r      <= '0;
      ky_r      <= '0;
      fx_r      <= '0;
      fy_r      <= '0;
      s1        <= 1'b0;
      zx1       <= 1'b0;
      zy1       <= 1'b0;
      k_r       <= '0;
      f_r       <= '0;
      s2        <= 1'b0;
      zx2       <= 1'b0;
      zy2       <= 1'b0;
      res_r     <= '0;
      dz_r      <= 1'b0;
      q         <= '0;
      dz        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_r   <= x;
          y_r   <= y;
          state <= LOG;
        end
        LOG: begin
          kx_r  <= kx_n;
          ky_r  <= ky_n;
          fx_r  <= frac_of(xa, kx_n);
          fy_r  <= frac_of(ya, ky_n);
          s1    <= x_r[15] ^ y_r[15];
          zx1   <= (x_r == 16'h0000);
          zy1   <= (y_r == 16'h0000);
          state <= SUB;
        end
        SUB: begin
          k_r   <= k_n;
          f_r   <= f_n;
          s2    <= s1;
          zx2   <= zx1;
          zy2   <= zy1;
          state <= ALOG;
        end
        ALOG: begin
          res_r <= res_n;
          dz_r  <= zy2;
          state <= OUT;
        end
        OUT: begin
          // First OUT edge publishes the result; it then holds until taken.
          if (!out_valid) begin
            q         <= res_r;
            dz        <= dz_r;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
